// File: rtl/dma_priority_resolver.sv
// dma_priority_resolver
// Bus-request and priority stage of an 8237-style DMA controller.
// It qualifies DREQ using the sense and mask settings, requests the bus with
// HRQ, and picks a winning channel under fixed or rotating priority. The
// winner holds DACK/grantChannel for one complete service.
//
//   state | meaning
//   IDLE  | no service in progress; HRQ low
//   REQ   | HRQ high, waiting for HLDA while a qualified request is present
//   GRANT | winner latched; DACK/grantValid held until transferDone or HLDA loss
module dma_priority_resolver #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NUM_CH-1:0]   DREQ,
  input  logic                HLDA,
  input  logic [NUM_CH-1:0]   maskReg,
  input  logic                priorityType,
  input  logic                dreqSenseLow,
  input  logic                controllerDisable,
  input  logic                transferDone,
  output logic                HRQ,
  output logic [NUM_CH-1:0]   DACK,
  output logic                grantValid,
  output logic [CH_W-1:0]     grantChannel,
  output logic [2*NUM_CH-1:0] priorityOrder
);

  // ch0 highest ... ch3 lowest
  localparam logic [2*NUM_CH-1:0] ORDER_DEFAULT = 8'b11_10_01_00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                hrq_q, hrq_d;
  logic [NUM_CH-1:0]   dack_q, dack_d;
  logic                gv_q, gv_d;
  logic [CH_W-1:0]     gch_q, gch_d;
  logic [2*NUM_CH-1:0] order_q, order_d;

  logic [NUM_CH-1:0]   eff_req;
  logic                any_req;
  logic [CH_W-1:0]     win_ch;
  logic [2*NUM_CH-1:0] rot_order;

  assign eff_req = (DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg;
  assign any_req = |eff_req;

  // After serving k: k becomes lowest and k+1 highest.
  assign rot_order = {gch_q, gch_q + 2'd3, gch_q + 2'd2, gch_q + 2'd1};

  // Scan from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    win_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eff_req[order_q[i*CH_W +: CH_W]]) begin
        win_ch = order_q[i*CH_W +: CH_W];
      end
    end
  end

  // Next-state, registered-output and priority-order logic.
  always_comb begin
    state_d = state_q;
    hrq_d   = hrq_q;
    dack_d  = dack_q;
    gv_d    = gv_q;
    gch_d   = gch_q;
    order_d = priorityType ? order_q : ORDER_DEFAULT;
    case (state_q)
      IDLE: begin
        if (any_req && !controllerDisable) begin
          state_d = REQ;
          hrq_d   = 1'b1;
        end
      end
      REQ: begin
        if (!any_req || controllerDisable) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
        end else if (HLDA) begin
          state_d = GRANT;
          dack_d  = {{(NUM_CH-1){1'b0}}, 1'b1} << win_ch;
          gv_d    = 1'b1;
          gch_d   = win_ch;
        end
      end
      GRANT: begin
        // Completion takes precedence over a simultaneous HLDA drop.
        if (transferDone) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
          dack_d  = '0;
          gv_d    = 1'b0;
          gch_d   = '0;
          if (priorityType) begin
            order_d = rot_order;
          end
        end else if (!HLDA) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
          dack_d  = '0;
          gv_d    = 1'b0;
          gch_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hrq_d   = 1'b0;
        dack_d  = '0;
        gv_d    = 1'b0;
        gch_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any service without rotating.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      hrq_q   <= 1'b0;
      dack_q  <= '0;
      gv_q    <= 1'b0;
      gch_q   <= '0;
      order_q <= ORDER_DEFAULT;
    end else begin
      state_q <= state_d;
      hrq_q   <= hrq_d;
      dack_q  <= dack_d;
      gv_q    <= gv_d;
      gch_q   <= gch_d;
      order_q <= order_d;
    end
  end

  assign HRQ           = hrq_q;
  assign DACK          = dack_q;
  assign grantValid    = gv_q;
  assign grantChannel  = gch_q;
  assign priorityOrder = order_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Testbench for dma_priority_resolver: expected DACK values are queued as
// each request is driven and popped when the grant appears.
module tb_dma_priority_resolver;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] maskReg;
  logic       priorityType;
  logic       dreqSenseLow;
  logic       controllerDisable;
  logic       transferDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic [7:0] priorityOrder;

  int n_run  = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  dma_priority_resolver #(.NUM_CH(4), .CH_W(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .maskReg(maskReg),
    .priorityType(priorityType), .dreqSenseLow(dreqSenseLow),
    .controllerDisable(controllerDisable), .transferDone(transferDone),
    .HRQ(HRQ), .DACK(DACK), .grantValid(grantValid),
    .grantChannel(grantChannel), .priorityOrder(priorityOrder)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    DREQ = 4'b0000; HLDA = 1'b0; maskReg = 4'b0000; dreqSenseLow = 1'b0;
    controllerDisable = 1'b0; transferDone = 1'b0;
    repeat (3) tick();
  endtask

  // From IDLE with a qualified request: one cycle to REQ, then HLDA and one cycle to GRANT.
  task automatic req_grant(output logic hrq_seen, output logic gv_seen,
                           output logic [3:0] dack_seen, output logic [1:0] ch_seen);
    tick();
    hrq_seen = HRQ;
    HLDA = 1'b1;
    tick();
    gv_seen = grantValid; dack_seen = DACK; ch_seen = grantChannel;
  endtask

  // End the service; the CPU drops HLDA once HRQ falls.
  task automatic finish_service();
    transferDone = 1'b1;
    tick();
    transferDone = 1'b0;
    HLDA = 1'b0;
  endtask

  task automatic test_reset();
    logic h, g; logic [3:0] d; logic [1:0] c;
    RESET_N = 1'b0;
    DREQ = 4'b0000; HLDA = 1'b0; maskReg = 4'b0000; priorityType = 1'b0;
    dreqSenseLow = 1'b0; controllerDisable = 1'b0; transferDone = 1'b0;
    repeat (2) tick();
    n_run++;
    if ({HRQ, DACK, grantValid, grantChannel, priorityOrder} !== {1'b0, 4'b0000, 1'b0, 2'b00, 8'hE4}) begin
      n_fail++;
      $display("FAIL reset_state: got hrq=%b dack=%b gv=%b ch=%0d order=%h, want 0 0000 0 0 e4",
               HRQ, DACK, grantValid, grantChannel, priorityOrder);
    end
    RESET_N = 1'b1;
    tick();
    DREQ = 4'b0001;
    exp_q.push_back(4'b0001);
    req_grant(h, g, d, c);
    n_run++;
    if (!g || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL reset_pre_grant: gv=%b, want 1", g);
    end else if (d !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL reset_pre_grant: dack=%b, want 0001", d);
    end
    RESET_N = 1'b0;
    #2;
    n_run++;
    if ({HRQ, DACK, grantValid, priorityOrder} !== {1'b0, 4'b0000, 1'b0, 8'hE4}) begin
      n_fail++;
      $display("FAIL reset_mid_grant: got hrq=%b dack=%b gv=%b order=%h, want 0 0000 0 e4",
               HRQ, DACK, grantValid, priorityOrder);
    end
    #3;
    RESET_N = 1'b1;
    settle();
  endtask

  task automatic test_fixed();
    logic h, g; logic [3:0] d; logic [1:0] c;
    logic [3:0] dreq_tab [2] = '{4'b0011, 4'b1110};
    logic [3:0] dack_tab [2] = '{4'b0001, 4'b0010};
    logic [1:0] ch_tab   [2] = '{2'd0, 2'd1};
    priorityType = 1'b0;
    for (int i = 0; i < 2; i++) begin
      DREQ = dreq_tab[i];
      exp_q.push_back(dack_tab[i]);
      req_grant(h, g, d, c);
      n_run++;
      if (h !== 1'b1) begin
        n_fail++;
        $display("FAIL fixed_hrq[%0d]: hrq=%b, want 1", i, h);
      end
      n_run++;
      if (!g || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fixed_grant_timeout[%0d]: gv=%b, want 1", i, g);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (d !== e || c !== ch_tab[i]) begin
          n_fail++;
          $display("FAIL fixed_grant[%0d]: dack=%b ch=%0d, want %b %0d", i, d, c, e, ch_tab[i]);
        end
      end
      finish_service();
      n_run++;
      if ({HRQ, DACK, grantValid} !== {1'b0, 4'b0000, 1'b0}) begin
        n_fail++;
        $display("FAIL fixed_done[%0d]: hrq=%b dack=%b gv=%b, want 0 0000 0", i, HRQ, DACK, grantValid);
      end
    end
    settle();
  endtask

  task automatic test_rotating();
    logic h, g; logic [3:0] d; logic [1:0] c;
    logic [3:0] dack_tab  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] order_tab [5] = '{8'b00_11_10_01, 8'b01_00_11_10, 8'b10_01_00_11,
                                  8'b11_10_01_00, 8'b00_11_10_01};
    priorityType = 1'b1;
    DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(dack_tab[i]);
      req_grant(h, g, d, c);
      n_run++;
      if (!g || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rot_grant_timeout[%0d]: gv=%b, want 1", i, g);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (d !== e) begin
          n_fail++;
          $display("FAIL rot_grant[%0d]: dack=%b, want %b", i, d, e);
        end
      end
      finish_service();
      n_run++;
      if (priorityOrder !== order_tab[i] || HRQ !== 1'b0) begin
        n_fail++;
        $display("FAIL rot_order[%0d]: order=%b hrq=%b, want %b 0", i, priorityOrder, HRQ, order_tab[i]);
      end
    end
    DREQ = 4'b0000;
    priorityType = 1'b0;
    tick();
    n_run++;
    if (priorityOrder !== 8'hE4) begin
      n_fail++;
      $display("FAIL rot_back_to_fixed: order=%h, want e4", priorityOrder);
    end
    settle();
  endtask

  task automatic test_mask_sense();
    logic h, g; logic [3:0] d; logic [1:0] c;
    priorityType = 1'b0;
    maskReg = 4'b0001; DREQ = 4'b0011;
    exp_q.push_back(4'b0010);
    req_grant(h, g, d, c);
    n_run++;
    if (!g || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL mask_grant: gv=%b, want 1", g);
    end else if (d !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL mask_grant: dack=%b, want 0010", d);
    end
    finish_service();
    maskReg = 4'b0000; dreqSenseLow = 1'b1; DREQ = 4'b1011;
    exp_q.push_back(4'b0100);
    req_grant(h, g, d, c);
    n_run++;
    if (!g || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sense_grant: gv=%b, want 1", g);
    end else if (d !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL sense_grant: dack=%b, want 0100", d);
    end
    finish_service();
    settle();
  endtask

  task automatic test_abort();
    logic h, g; logic [3:0] d; logic [1:0] c;
    priorityType = 1'b0;
    DREQ = 4'b0100;
    tick();
    n_run++;
    if (HRQ !== 1'b1) begin
      n_fail++;
      $display("FAIL withdraw_hrq_up: hrq=%b, want 1", HRQ);
    end
    DREQ = 4'b0000;
    tick();
    n_run++;
    if (HRQ !== 1'b0 || DACK !== 4'b0000) begin
      n_fail++;
      $display("FAIL withdraw: hrq=%b dack=%b, want 0 0000", HRQ, DACK);
    end
    priorityType = 1'b1;
    DREQ = 4'b0010;
    exp_q.push_back(4'b0010);
    req_grant(h, g, d, c);
    n_run++;
    if (!g || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL abort_grant: gv=%b, want 1", g);
    end else if (d !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL abort_grant: dack=%b, want 0010", d);
    end
    HLDA = 1'b0;
    tick();
    n_run++;
    if ({DACK, grantValid, priorityOrder} !== {4'b0000, 1'b0, 8'hE4}) begin
      n_fail++;
      $display("FAIL hlda_abort: dack=%b gv=%b order=%h, want 0000 0 e4", DACK, grantValid, priorityOrder);
    end
    // Back in IDLE with DREQ still up; next tick enters REQ, then grant again.
    exp_q.push_back(4'b0010);
    req_grant(h, g, d, c);
    n_run++;
    if (!g || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL simul_grant: gv=%b, want 1", g);
    end else if (d !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL simul_grant: dack=%b, want 0010", d);
    end
    transferDone = 1'b1; HLDA = 1'b0;
    tick();
    transferDone = 1'b0; DREQ = 4'b0000;
    n_run++;
    if (priorityOrder !== 8'b01_00_11_10 || grantValid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_done_hlda: order=%b gv=%b, want 01001110 0", priorityOrder, grantValid);
    end
    tick();
    transferDone = 1'b1;
    tick();
    transferDone = 1'b0;
    n_run++;
    if (priorityOrder !== 8'b01_00_11_10) begin
      n_fail++;
      $display("FAIL done_outside_grant: order=%b, want 01001110", priorityOrder);
    end
    priorityType = 1'b0;
    settle();
  endtask

  task automatic test_disable();
    logic h, g; logic [3:0] d; logic [1:0] c;
    logic hrq_any;
    priorityType = 1'b0;
    controllerDisable = 1'b1;
    DREQ = 4'b1111;
    hrq_any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      hrq_any = hrq_any | HRQ;
    end
    n_run++;
    if (hrq_any !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_idle: hrq seen=%b, want 0", hrq_any);
    end
    controllerDisable = 1'b0;
    DREQ = 4'b0001;
    tick();
    controllerDisable = 1'b1;
    tick();
    n_run++;
    if (HRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_in_req: hrq=%b, want 0", HRQ);
    end
    controllerDisable = 1'b0;
    DREQ = 4'b1111;
    exp_q.push_back(4'b0001);
    req_grant(h, g, d, c);
    n_run++;
    if (!g || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL disable_grant: gv=%b, want 1", g);
    end else if (d !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL disable_grant: dack=%b, want 0001", d);
    end
    controllerDisable = 1'b1;
    DREQ = 4'b0000;
    maskReg = 4'b1111;
    repeat (3) tick();
    n_run++;
    if ({grantValid, DACK, grantChannel, HRQ} !== {1'b1, 4'b0001, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL disable_mid_grant: gv=%b dack=%b ch=%0d hrq=%b, want 1 0001 0 1",
               grantValid, DACK, grantChannel, HRQ);
    end
    maskReg = 4'b0000;
    DREQ = 4'b1111;
    finish_service();
    n_run++;
    if (grantValid !== 1'b0 || DACK !== 4'b0000) begin
      n_fail++;
      $display("FAIL disable_done: gv=%b dack=%b, want 0 0000", grantValid, DACK);
    end
    hrq_any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      hrq_any = hrq_any | HRQ;
    end
    n_run++;
    if (hrq_any !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_after_done: hrq seen=%b, want 0", hrq_any);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rotating();
    test_mask_sense();
    test_abort();
    test_disable();
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
